// File: rtl/bnn_pkg.sv
// Shared constants for the BNN accelerator: class count, FC state
// encoding, default accumulator width and the binarize threshold.
package bnn_pkg;

  localparam int N_CLASS       = 10;
  localparam int DEFAULT_ACC_W = 10;

  // FC layer state encoding
  localparam logic [1:0] FC_IDLE  = 2'd0;
  localparam logic [1:0] FC_ACCUM = 2'd1;
  localparam logic [1:0] FC_DRAIN = 2'd2;

  // Samples strictly above this value binarize to +1, everything else to -1
  localparam logic signed [4:0] BIN_THRESH = 5'sd0;

  // Returns 1 for +1, 0 for -1
  function automatic logic binarize(input logic signed [4:0] d);
    return (d > BIN_THRESH);
  endfunction

endpackage

// File: rtl/bnn_fc_lane.sv
// One class lane of the binary FC layer: a signed accumulator that is
// cleared on clr and moves by +1 (x matches w) or -1 (mismatch) on en.
module bnn_fc_lane
  import bnn_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    x,
  input  logic                    w,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] acc_reg;

  // XNOR-popcount update; clear has priority so a squashed sample never lands
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      if (x ~^ w) acc_reg <= acc_reg + ACC_W'(1);
      else        acc_reg <= acc_reg - ACC_W'(1);
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/bnn_fc_layer.sv
// Binary fully-connected output layer. Accepts N_IN pooled samples,
// binarizes them, reads one weight word per sample from an external
// synchronous ROM and accumulates ten XNOR-popcount class scores.
module bnn_fc_layer
  import bnn_pkg::*;
#(
  parameter int N_IN  = 121,
  parameter int ACC_W = DEFAULT_ACC_W,
  parameter int AW    = 7
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic signed [4:0]       din,
  input  logic                    din_valid,
  output logic [AW-1:0]           w_addr,
  output logic                    w_rd_en,
  input  logic [N_CLASS-1:0]      w_data,
  output logic signed [ACC_W-1:0] fc_result_0,
  output logic signed [ACC_W-1:0] fc_result_1,
  output logic signed [ACC_W-1:0] fc_result_2,
  output logic signed [ACC_W-1:0] fc_result_3,
  output logic signed [ACC_W-1:0] fc_result_4,
  output logic signed [ACC_W-1:0] fc_result_5,
  output logic signed [ACC_W-1:0] fc_result_6,
  output logic signed [ACC_W-1:0] fc_result_7,
  output logic signed [ACC_W-1:0] fc_result_8,
  output logic signed [ACC_W-1:0] fc_result_9,
  output logic                    fc_result_valid,
  output logic                    busy
);

  // Counter is wide enough to hold N_IN itself, independent of AW
  localparam int CNT_W = $clog2(N_IN + 1);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] in_cnt_reg;
  logic             x_reg;
  logic             xv_reg;
  logic             valid_reg;
  logic             accept;
  logic             last_accept;

  logic signed [ACC_W-1:0] acc_vec [N_CLASS];

  // start always wins over a coincident sample
  assign accept      = (state_reg == FC_ACCUM) && din_valid && !start;
  assign last_accept = accept && (in_cnt_reg == CNT_W'(N_IN - 1));

  // Next-state logic; start re-arms from any state
  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = FC_ACCUM;
    end else begin
      case (state_reg)
        FC_IDLE:  state_next = FC_IDLE;
        FC_ACCUM: if (last_accept) state_next = FC_DRAIN;
        FC_DRAIN: state_next = FC_IDLE;
        default:  state_next = FC_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= FC_IDLE;
    else       state_reg <= state_next;
  end

  // Input counter; only start brings it back to zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       in_cnt_reg <= '0;
    else if (start)  in_cnt_reg <= '0;
    else if (accept) in_cnt_reg <= in_cnt_reg + CNT_W'(1);
  end

  // Pipeline stage aligning the binarized sample with the ROM read data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_reg  <= 1'b0;
      xv_reg <= 1'b0;
    end else begin
      xv_reg <= accept;
      if (accept) x_reg <= binarize(din);
    end
  end

  // Result pulse: registered alongside the final accumulate in DRAIN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) valid_reg <= 1'b0;
    else       valid_reg <= (state_reg == FC_DRAIN) && !start;
  end

  generate
    for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_lane
      bnn_fc_lane #(
        .ACC_W (ACC_W)
      ) u_lane (
        .clk  (clk),
        .rstn (rstn),
        .clr  (start),
        .en   (xv_reg),
        .x    (x_reg),
        .w    (w_data[gi]),
        .acc  (acc_vec[gi])
      );
    end
  endgenerate

  assign w_addr          = AW'(in_cnt_reg);
  assign w_rd_en         = accept;
  assign fc_result_valid = valid_reg;
  assign busy            = (state_reg != FC_IDLE);

  assign fc_result_0 = acc_vec[0];
  assign fc_result_1 = acc_vec[1];
  assign fc_result_2 = acc_vec[2];
  assign fc_result_3 = acc_vec[3];
  assign fc_result_4 = acc_vec[4];
  assign fc_result_5 = acc_vec[5];
  assign fc_result_6 = acc_vec[6];
  assign fc_result_7 = acc_vec[7];
  assign fc_result_8 = acc_vec[8];
  assign fc_result_9 = acc_vec[9];

endmodule

// File: tb/tb_bnn_fc_layer.sv
// Self-checking bench for bnn_fc_layer: a full-size instance (N_IN=121)
// driven through directed images, and a small instance (N_IN=4) for the
// overrun case. Expected scores come from a bench-side model pushed into
// a scoreboard queue and popped when fc_result_valid appears.
module tb_bnn_fc_layer;
  import bnn_pkg::*;

  localparam int N_A   = 121;
  localparam int N_B   = 4;
  localparam int ACC_W = 10;
  localparam int AW    = 7;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  // Full-size instance
  logic                    start_a = 1'b0;
  logic                    dv_a    = 1'b0;
  logic signed [4:0]       din_a   = '0;
  logic [AW-1:0]           waddr_a;
  logic                    rd_a;
  logic [9:0]              wdata_a = '0;
  logic signed [ACC_W-1:0] res_a [10];
  logic                    fv_a, busy_a;

  // Small instance
  logic                    start_b = 1'b0;
  logic                    dv_b    = 1'b0;
  logic signed [4:0]       din_b   = '0;
  logic [AW-1:0]           waddr_b;
  logic                    rd_b;
  logic [9:0]              wdata_b = '0;
  logic signed [ACC_W-1:0] res_b [10];
  logic                    fv_b, busy_b;

  bnn_fc_layer #(.N_IN(N_A), .ACC_W(ACC_W), .AW(AW)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .din(din_a), .din_valid(dv_a),
    .w_addr(waddr_a), .w_rd_en(rd_a), .w_data(wdata_a),
    .fc_result_0(res_a[0]), .fc_result_1(res_a[1]), .fc_result_2(res_a[2]),
    .fc_result_3(res_a[3]), .fc_result_4(res_a[4]), .fc_result_5(res_a[5]),
    .fc_result_6(res_a[6]), .fc_result_7(res_a[7]), .fc_result_8(res_a[8]),
    .fc_result_9(res_a[9]), .fc_result_valid(fv_a), .busy(busy_a)
  );

  bnn_fc_layer #(.N_IN(N_B), .ACC_W(ACC_W), .AW(AW)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .din(din_b), .din_valid(dv_b),
    .w_addr(waddr_b), .w_rd_en(rd_b), .w_data(wdata_b),
    .fc_result_0(res_b[0]), .fc_result_1(res_b[1]), .fc_result_2(res_b[2]),
    .fc_result_3(res_b[3]), .fc_result_4(res_b[4]), .fc_result_5(res_b[5]),
    .fc_result_6(res_b[6]), .fc_result_7(res_b[7]), .fc_result_8(res_b[8]),
    .fc_result_9(res_b[9]), .fc_result_valid(fv_b), .busy(busy_b)
  );

  // Synchronous weight ROMs
  logic [9:0] rom_a [128];
  logic [9:0] rom_b [128];

  always @(posedge clk) begin
    if (rd_a) wdata_a <= rom_a[waddr_a];
    if (rd_b) wdata_b <= rom_b[waddr_b];
  end

  // Event counters sampled on the falling edge
  int pulses_a = 0;
  int pulses_b = 0;
  int reads_b  = 0;

  always @(negedge clk) begin
    if (fv_a === 1'b1) pulses_a <= pulses_a + 1;
    if (fv_b === 1'b1) pulses_b <= pulses_b + 1;
    if (rd_b === 1'b1) reads_b  <= reads_b + 1;
  end

  // Model state and scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  int exp_acc [10];
  int mcnt = 0;
  bit armed = 1'b0;
  int sb_q [$];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic fill_rom_a(input logic [9:0] pat);
    for (int i = 0; i < 128; i++) rom_a[i] = pat;
  endtask

  // Pulse start on instance A and arm the model
  task automatic start_image_a(input string tag);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 10; k++) exp_acc[k] = 0;
    mcnt  = 0;
    armed = 1'b1;
    chk({tag, "_busy"}, busy_a, 1);
    chk({tag, "_clr0"}, res_a[0], 0);
    chk({tag, "_clr9"}, res_a[9], 0);
    chk({tag, "_addr0"}, waddr_a, 0);
    $display("txn %s: start issued", tag);
  endtask

  // Back-to-back samples alternating va/vb; model tracks acceptance
  task automatic feed_a(input int n, input logic signed [4:0] va,
                        input logic signed [4:0] vb);
    logic xb;
    for (int i = 0; i < n; i++) begin
      din_a = (i % 2 == 0) ? va : vb;
      dv_a  = 1'b1;
      if (armed && mcnt < N_A) begin
        xb = (din_a > 5'sd0);
        for (int k = 0; k < 10; k++) begin
          if (xb == rom_a[mcnt][k]) exp_acc[k]++;
          else                      exp_acc[k]--;
        end
        mcnt++;
        if (mcnt == N_A) begin
          for (int k = 0; k < 10; k++) sb_q.push_back(exp_acc[k]);
          armed = 1'b0;
        end
      end
      @(negedge clk);
    end
    dv_a = 1'b0;
  endtask

  // Called on the falling edge right after the last acceptance edge
  task automatic check_image_a(input string tag);
    int e;
    chk({tag, "_early"}, fv_a, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, fv_a, 1);
    if (fv_a === 1'b1 && sb_q.size() >= 10) begin
      for (int k = 0; k < 10; k++) begin
        e = sb_q.pop_front();
        chk($sformatf("%s_res%0d", tag, k), res_a[k], e);
      end
    end else begin
      sb_q.delete();
    end
    @(negedge clk);
    chk({tag, "_pulse_end"}, fv_a, 0);
    chk({tag, "_idle"}, busy_a, 0);
    chk({tag, "_hold"}, res_a[0], exp_acc[0]);
    $display("txn %s: scores %0d %0d ... %0d", tag, res_a[0], res_a[1], res_a[9]);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom_b[i] = 10'h3FF;
    fill_rom_a(10'h3FF);

    // Reset
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 10; k++) chk($sformatf("rst_res%0d", k), res_a[k], 0);
    chk("rst_valid", fv_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_rd", rd_a, 0);
    chk("rst_addr", waddr_a, 0);
    $display("txn reset: outputs idle");
    rstn = 1'b1;
    @(negedge clk);

    // All weights +1, all samples positive
    fill_rom_a(10'h3FF);
    start_image_a("pos");
    feed_a(N_A, 5'sd3, 5'sd3);
    check_image_a("pos");
    chk("pos_val", res_a[4], 121);

    // Zero binarizes to -1
    start_image_a("zero");
    feed_a(N_A, 5'sd0, 5'sd0);
    check_image_a("zero");
    chk("zero_val", res_a[7], -121);

    // Alternating weights and samples
    fill_rom_a(10'h155);
    start_image_a("alt");
    feed_a(N_A, 5'sd1, -5'sd4);
    check_image_a("alt");
    chk("alt_even", res_a[0], 1);
    chk("alt_odd", res_a[1], -1);

    // Small instance: samples beyond N_IN dropped
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din_b = 5'sd1;
      dv_b  = 1'b1;
      @(negedge clk);
    end
    dv_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("ovr_reads", reads_b, N_B);
    chk("ovr_pulses", pulses_b, 1);
    for (int k = 0; k < 10; k++) chk($sformatf("ovr_res%0d", k), res_b[k], 4);
    chk("ovr_busy", busy_b, 0);
    $display("txn overrun: reads=%0d pulses=%0d res0=%0d", reads_b, pulses_b, res_b[0]);
    @(negedge clk);

    // Restart mid-image, then a clean image with all-zero weights
    fill_rom_a(10'h3FF);
    start_image_a("abort");
    feed_a(50, 5'sd1, 5'sd1);
    fill_rom_a(10'h000);
    start_image_a("restart");
    feed_a(N_A, 5'sd1, 5'sd1);
    check_image_a("restart");
    chk("restart_val", res_a[5], -121);

    // Reset mid-image
    fill_rom_a(10'h3FF);
    start_image_a("rstmid");
    feed_a(30, 5'sd2, 5'sd2);
    rstn  = 1'b0;
    armed = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) chk($sformatf("rstmid_res%0d", k), res_a[k], 0);
    chk("rstmid_valid", fv_a, 0);
    chk("rstmid_busy", busy_a, 0);
    chk("rstmid_addr", waddr_a, 0);
    @(negedge clk);
    rstn  = 1'b1;
    din_a = 5'sd1;
    dv_a  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid_ign_rd%0d", i), rd_a, 0);
      chk($sformatf("rstmid_ign_busy%0d", i), busy_a, 0);
    end
    dv_a = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("total_pulses_a", pulses_a, 4);
    $display("txn rstmid: pulses_a=%0d", pulses_a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
